// File: rtl/data_sram_responder_pkg.sv
// Shared constants for the data_sram responder: MMIO window decode, offsets,
// read-latency bounds and the byte-lane merge helper.
package data_sram_responder_pkg;

  localparam int unsigned DATA_W       = 32;
  localparam int unsigned RD_LAT_MIN   = 1;
  localparam int unsigned RD_LAT_MAX   = 4;

  localparam logic [15:0] MMIO_HI_DEF  = 16'hbfaf;
  localparam logic [15:0] LED_OFF      = 16'hf000;
  localparam logic [15:0] TIMER_OFF    = 16'he000;
  localparam logic [15:0] SCRATCH_OFF  = 16'hf010;

  // Replace only the byte lanes whose enable bit is set.
  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_val,
                                                    input logic [DATA_W-1:0] new_val,
                                                    input logic [3:0]        lane_en);
    logic [DATA_W-1:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (lane_en[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/data_sram_responder_sram_bytewen_array.sv
// Single-port word RAM with per-byte write enables and a registered read port
// that only updates on read accesses (holds otherwise).
module sram_bytewen_array #(
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [3:0]    wen,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [31:0] mem [DEPTH];

  // Array storage carries no reset.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (wen[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (en && (wen == 4'h0)) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_sram_responder.sv
// Responder for the data_sram interface: byte-writable RAM, MMIO window
// (LED, free-running timer, scratch) and a configurable read-latency pipeline.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int unsigned AW      = 10,
  parameter int unsigned RD_LAT  = 1,
  parameter logic [15:0] MMIO_HI = MMIO_HI_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [15:0] led,
  output logic [31:0] timer
);

  if ((RD_LAT < RD_LAT_MIN) || (RD_LAT > RD_LAT_MAX)) begin : g_bad_rd_lat
    $error("data_sram_responder: RD_LAT must be within 1..4");
  end

  logic        is_mmio;
  logic [15:0] off;
  logic        wr;
  logic        rd;
  logic        wr_led;
  logic        wr_timer;
  logic        wr_scratch;
  logic [31:0] scratch;
  logic [31:0] mmio_rd;
  logic [31:0] ram_q;
  logic [31:0] mmio_q;
  logic        sel_mmio_q;
  logic        rd_valid_q;
  logic [31:0] s0_data;

  assign is_mmio    = (data_sram_addr[31:16] == MMIO_HI);
  assign off        = data_sram_addr[15:0];
  assign wr         = data_sram_en && (data_sram_wen != 4'h0);
  assign rd         = data_sram_en && (data_sram_wen == 4'h0);
  assign wr_led     = wr && is_mmio && (off == LED_OFF);
  assign wr_timer   = wr && is_mmio && (off == TIMER_OFF);
  assign wr_scratch = wr && is_mmio && (off == SCRATCH_OFF);

  sram_bytewen_array #(.AW(AW)) u_ram (
    .clk   (clk),
    .reset (reset),
    .en    (data_sram_en && !is_mmio),
    .wen   (data_sram_wen),
    .addr  (data_sram_addr[AW+1:2]),
    .wdata (data_sram_wdata),
    .rdata (ram_q)
  );

  // MMIO registers; a timer write wins over the increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      led     <= '0;
      scratch <= '0;
      timer   <= '0;
    end else begin
      if (wr_led && data_sram_wen[0]) led[7:0]  <= data_sram_wdata[7:0];
      if (wr_led && data_sram_wen[1]) led[15:8] <= data_sram_wdata[15:8];
      if (wr_scratch) scratch <= merge_bytes(scratch, data_sram_wdata, data_sram_wen);
      if (wr_timer) timer <= merge_bytes(timer, data_sram_wdata, data_sram_wen);
      else          timer <= timer + 32'd1;
    end
  end

  always_comb begin
    mmio_rd = '0;
    case (off)
      LED_OFF:     mmio_rd = {16'h0000, led};
      TIMER_OFF:   mmio_rd = timer;
      SCRATCH_OFF: mmio_rd = scratch;
      default:     mmio_rd = '0;
    endcase
  end

  // First read stage: MMIO value and source select captured at the request edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      sel_mmio_q <= 1'b0;
      mmio_q     <= '0;
    end else begin
      rd_valid_q <= rd;
      if (rd) begin
        sel_mmio_q <= is_mmio;
        mmio_q     <= mmio_rd;
      end
    end
  end

  assign s0_data = sel_mmio_q ? mmio_q : ram_q;

  if (RD_LAT <= 1) begin : g_lat1
    logic unused_valid;
    assign unused_valid    = rd_valid_q;
    assign data_sram_rdata = s0_data;
  end else begin : g_pipe
    localparam int unsigned N = RD_LAT - 1;
    logic [N-1:0] vld_q;
    logic [31:0]  dat_q [N];
    logic         unused_tail;

    // Each stage loads only when its predecessor holds a completed read.
    always_ff @(posedge clk) begin
      if (reset) begin
        vld_q <= '0;
        for (int i = 0; i < int'(N); i++) dat_q[i] <= '0;
      end else begin
        vld_q[0] <= rd_valid_q;
        if (rd_valid_q) dat_q[0] <= s0_data;
        for (int i = 1; i < int'(N); i++) begin
          vld_q[i] <= vld_q[i-1];
          if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
        end
      end
    end

    assign unused_tail     = vld_q[N-1];
    assign data_sram_rdata = dat_q[N-1];
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: three instances (RD_LAT 1, 2, 3)
// share one stimulus stream; expected values are hand-computed constants.
module tb_data_sram_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata1, rdata2, rdata3;
  logic [15:0] led1, led2, led3;
  logic [31:0] timer1, timer2, timer3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  data_sram_responder #(.AW(10), .RD_LAT(1)) u_lat1 (
    .clk(clk), .reset(reset), .data_sram_en(en), .data_sram_wen(wen),
    .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata1),
    .led(led1), .timer(timer1));

  data_sram_responder #(.AW(10), .RD_LAT(2)) u_lat2 (
    .clk(clk), .reset(reset), .data_sram_en(en), .data_sram_wen(wen),
    .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata2),
    .led(led2), .timer(timer2));

  data_sram_responder #(.AW(10), .RD_LAT(3)) u_lat3 (
    .clk(clk), .reset(reset), .data_sram_en(en), .data_sram_wen(wen),
    .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata3),
    .led(led3), .timer(timer3));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic req(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    en    = e;
    wen   = w;
    addr  = a;
    wdata = d;
  endtask

  initial begin
    reset = 1'b1;
    req(1'b0, 4'h0, 32'h0, 32'h0);
    repeat (3) step();
    check_val("rst_rdata", rdata1, 32'h0);
    check_val("rst_led", {16'h0, led1}, 32'h0);
    check_val("rst_timer", timer1, 32'h0);
    reset = 1'b0;
    check_val("timer_first", timer1, 32'h0);

    // Preload words 0..2 while watching the timer count up.
    req(1'b1, 4'hf, 32'h0000_0000, 32'h1); step();
    check_val("timer_1", timer1, 32'h1);
    req(1'b1, 4'hf, 32'h0000_0004, 32'h2); step();
    check_val("timer_2", timer1, 32'h2);
    req(1'b1, 4'hf, 32'h0000_0008, 32'h3); step();
    check_val("timer_3", timer1, 32'h3);

    // Back-to-back reads across all three latencies.
    req(1'b1, 4'h0, 32'h0000_0000, 32'h0); step();
    check_val("e1_lat1", rdata1, 32'h1);
    check_val("e1_lat3", rdata3, 32'h0);
    req(1'b1, 4'h0, 32'h0000_0004, 32'h0); step();
    check_val("e2_lat1", rdata1, 32'h2);
    check_val("e2_lat2", rdata2, 32'h1);
    check_val("e2_lat3", rdata3, 32'h0);
    req(1'b1, 4'h0, 32'h0000_0008, 32'h0); step();
    check_val("e3_lat1", rdata1, 32'h3);
    check_val("e3_lat2", rdata2, 32'h2);
    check_val("e3_lat3", rdata3, 32'h1);
    req(1'b0, 4'h0, 32'h0, 32'h0); step();
    check_val("e4_lat1", rdata1, 32'h3);
    check_val("e4_lat2", rdata2, 32'h3);
    check_val("e4_lat3", rdata3, 32'h2);
    step();
    check_val("e5_lat3", rdata3, 32'h3);
    step();
    check_val("e6_lat3_hold", rdata3, 32'h3);

    // Byte-lane write then immediate read of the same word.
    req(1'b1, 4'hf, 32'h0000_1000, 32'haabb_ccdd); step();
    req(1'b1, 4'h2, 32'h0000_1000, 32'h0000_1100); step();
    req(1'b1, 4'h0, 32'h0000_1000, 32'h0); step();
    check_val("byte_merge", rdata1, 32'haabb_11dd);
    req(1'b0, 4'h0, 32'h0, 32'h0); step();
    check_val("hold_idle", rdata1, 32'haabb_11dd);
    req(1'b1, 4'h0, 32'h0000_0004, 32'h0); step();
    check_val("read_w1", rdata1, 32'h2);
    req(1'b1, 4'h0, 32'h0000_0000, 32'h0); step();
    check_val("alias_0x1000", rdata1, 32'haabb_11dd);
    req(1'b1, 4'hf, 32'h0000_1004, 32'h5); step();
    req(1'b1, 4'h0, 32'h0000_0004, 32'h0); step();
    check_val("index_wrap", rdata1, 32'h5);

    // LED and scratch registers, unmapped offset.
    req(1'b1, 4'h3, 32'hbfaf_f000, 32'h0000_a5a5); step();
    check_val("led_write", {16'h0, led1}, 32'h0000_a5a5);
    req(1'b1, 4'hc, 32'hbfaf_f000, 32'hffff_0000); step();
    check_val("led_upper_lanes", {16'h0, led1}, 32'h0000_a5a5);
    req(1'b1, 4'h1, 32'hbfaf_f000, 32'h0000_003c); step();
    check_val("led_lane0", {16'h0, led1}, 32'h0000_a53c);
    req(1'b1, 4'h0, 32'hbfaf_f004, 32'h0); step();
    check_val("mmio_unmapped", rdata1, 32'h0);
    req(1'b1, 4'h0, 32'hbfaf_f000, 32'h0); step();
    check_val("led_read", rdata1, 32'h0000_a53c);
    req(1'b1, 4'hf, 32'hbfaf_f010, 32'hdead_beef); step();
    req(1'b1, 4'h1, 32'hbfaf_f010, 32'h0000_0011); step();
    req(1'b1, 4'h0, 32'hbfaf_f010, 32'h0); step();
    check_val("scratch_read", rdata1, 32'hdead_be11);
    req(1'b1, 4'h0, 32'h0000_f000, 32'h0); step();
    check_val("ram_not_mmio", rdata1, 32'haabb_11dd);

    // Timer load, pre-increment read, wrap.
    req(1'b1, 4'hf, 32'hbfaf_e000, 32'hffff_fffe); step();
    check_val("timer_load", timer1, 32'hffff_fffe);
    req(1'b1, 4'h0, 32'hbfaf_e000, 32'h0); step();
    check_val("timer_inc", timer1, 32'hffff_ffff);
    check_val("timer_read", rdata1, 32'hffff_fffe);
    req(1'b0, 4'h0, 32'h0, 32'h0); step();
    check_val("timer_wrap", timer1, 32'h0);
    step();
    check_val("timer_after_wrap", timer1, 32'h1);
    check_val("timer_rd_hold", rdata1, 32'hffff_fffe);
    req(1'b1, 4'hf, 32'hbfaf_f004, 32'h1234_5678); step();
    req(1'b1, 4'h0, 32'hbfaf_f004, 32'h0); step();
    check_val("unmapped_write", rdata1, 32'h0);

    // Reset with a read in flight in the RD_LAT=2 pipeline.
    req(1'b1, 4'h0, 32'h0000_0004, 32'h0); step();
    reset = 1'b1;
    req(1'b0, 4'h0, 32'h0, 32'h0); step();
    check_val("midrst_lat2", rdata2, 32'h0);
    check_val("midrst_lat1", rdata1, 32'h0);
    check_val("midrst_led", {16'h0, led2}, 32'h0);
    check_val("midrst_timer", timer3, 32'h0);
    reset = 1'b0;
    step();
    step();
    check_val("no_stale_lat2", rdata2, 32'h0);
    req(1'b1, 4'h0, 32'hbfaf_f010, 32'h0); step();
    check_val("scratch_rst", rdata1, 32'h0);
    req(1'b1, 4'h0, 32'h0000_0004, 32'h0); step();
    check_val("post_rst_lat1", rdata1, 32'h5);
    req(1'b0, 4'h0, 32'h0, 32'h0); step();
    check_val("post_rst_lat2", rdata2, 32'h5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
